// File: rtl/c_skid_stage_if.sv
// c_skid_stage_if
//
// Purpose: bundles both valid/ready channels of a skid stage.
//   push_* is the upstream (producer -> stage) channel.
//   pop_*  is the downstream (stage -> consumer) channel.
//
// Modports:
//   slave  - the stage itself: it receives push words and drives pop words.
//   master - the environment around the stage: it produces push words and
//            consumes pop words.
//
// Parameters:
//   width  - data word width in bits
//   offset - left index of data vectors; range is [offset:offset+width-1]
interface c_skid_stage_if #(
    parameter int width  = 32,
    parameter int offset = 0
);
    logic                         push_valid;
    logic [offset:offset+width-1] push_data;
    logic                         push_ready;
    logic                         pop_valid;
    logic [offset:offset+width-1] pop_data;
    logic                         pop_ready;

    modport slave (
        input  push_valid,
        input  push_data,
        output push_ready,
        output pop_valid,
        output pop_data,
        input  pop_ready
    );

    modport master (
        output push_valid,
        output push_data,
        input  push_ready,
        input  pop_valid,
        input  pop_data,
        output pop_ready
    );
endinterface

// File: rtl/c_skid_stage.sv
// c_skid_stage
//
// Purpose: two-entry elastic pipeline stage. A main register holds the head
// word and drives pop_data; a skid register absorbs one extra word so that
// upstream can keep pushing for the cycle in which downstream stalls.
// push_ready, pop_valid and pop_data come from flops (gated only by the
// active enable), so no combinational path crosses the stage.
//
// Ports:
//   clk        - clock
//   reset      - asynchronous, active-high reset
//   active     - stage enable; when low everything holds and no handshake fires
//   bus        - c_skid_stage_if.slave (push_valid/push_data/push_ready,
//                pop_valid/pop_data/pop_ready)
//   occupancy  - number of words held (0..2)
//
// Parameters:
//   width       - data word width
//   offset      - left index of data vectors
//   reset_value - value on pop_data while empty after reset
module c_skid_stage #(
    parameter int               width       = 32,
    parameter int               offset      = 0,
    parameter logic [width-1:0] reset_value = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    c_skid_stage_if.slave        bus,
    output logic [1:0]           occupancy
);

    // Encoding equals the occupancy count, so occupancy is the state flop.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                       state_reg;
    logic [offset:offset+width-1] main_reg;
    logic [offset:offset+width-1] skid_reg;
    logic                         push_fire;
    logic                         pop_fire;

    assign bus.push_ready = active & (state_reg != FULL);
    assign bus.pop_valid  = active & (state_reg != EMPTY);
    assign bus.pop_data   = main_reg;
    assign occupancy      = state_reg;

    // active is already folded into push_ready/pop_valid.
    assign push_fire = bus.push_valid & bus.push_ready;
    assign pop_fire  = bus.pop_valid  & bus.pop_ready;

    // Data registers load only on a push or a skid->main refill; otherwise
    // they hold, which also keeps the last popped word on pop_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= EMPTY;
            main_reg  <= reset_value;
            skid_reg  <= reset_value;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push_fire) begin
                        main_reg  <= bus.push_data;
                        state_reg <= ONE;
                    end
                end
                ONE: begin
                    if (push_fire && pop_fire) begin
                        // Head leaves and the new word replaces it directly.
                        main_reg <= bus.push_data;
                    end else if (push_fire) begin
                        // Head is stalled: park the new word behind it.
                        skid_reg  <= bus.push_data;
                        state_reg <= FULL;
                    end else if (pop_fire) begin
                        state_reg <= EMPTY;
                    end
                end
                FULL: begin
                    // push_ready is low here, so only a pop can happen.
                    if (pop_fire) begin
                        main_reg  <= skid_reg;
                        state_reg <= ONE;
                    end
                end
                default: begin
                    // Unused encoding: recover to a clean empty stage.
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c_skid_stage.sv
module tb_c_skid_stage;
    localparam int               W   = 32;
    localparam int               OFS = 4;
    localparam logic [W-1:0]     RV  = 32'hDEAD_BEEF;

    logic       clk;
    logic       reset;
    logic       active;
    logic [1:0] occupancy;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] q[$];

    c_skid_stage_if #(.width(W), .offset(OFS)) bus ();

    c_skid_stage #(
        .width       (W),
        .offset      (OFS),
        .reset_value (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .bus       (bus),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven. Records handshakes into
    // the scoreboard, then advances to the next posedge+1.
    task automatic cycle();
        logic [W-1:0] exp_word;
        #1;
        check("occupancy_vs_model", {62'd0, occupancy}, 64'(q.size()));
        if (bus.pop_valid && bus.pop_ready) begin
            check("pop_has_expected", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                exp_word = q.pop_front();
                check("pop_data_order", {32'd0, bus.pop_data}, {32'd0, exp_word});
            end
        end
        if (bus.push_valid && bus.push_ready) q.push_back(bus.push_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        reset          = 1'b1;
        active         = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'h1234_5678;
        bus.pop_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pop_valid", {63'd0, bus.pop_valid}, 64'd0);
        check("reset_occupancy", {62'd0, occupancy}, 64'd0);
        check("reset_push_ready", {63'd0, bus.push_ready}, 64'd1);
        check("reset_pop_data", {32'd0, bus.pop_data}, {32'd0, RV});
        bus.push_valid = 1'b0;
        reset          = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- streaming ----------------
        for (int i = 1; i <= 32; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = W'(i);
            bus.pop_ready  = 1'b1;
            cycle();
            check("stream_data", {32'd0, bus.pop_data}, 64'(i));
            check("stream_occupancy", {62'd0, occupancy}, 64'd1);
        end
        bus.push_valid = 1'b0;
        cycle();
        check("stream_drained", {62'd0, occupancy}, 64'd0);

        // ---------------- backpressure ----------------
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'hA;
        cycle();
        bus.push_data  = 32'hB;
        cycle();
        check("bp_push_ready_full", {63'd0, bus.push_ready}, 64'd0);
        check("bp_occupancy_full", {62'd0, occupancy}, 64'd2);
        bus.push_data  = 32'hC;
        cycle();
        check("bp_c_held", {62'd0, occupancy}, 64'd2);
        check("bp_head_a", {32'd0, bus.pop_data}, 64'hA);
        bus.pop_ready = 1'b1;
        cycle();
        check("bp_head_b", {32'd0, bus.pop_data}, 64'hB);
        cycle();
        check("bp_head_c", {32'd0, bus.pop_data}, 64'hC);
        bus.push_valid = 1'b0;
        cycle();
        check("bp_drained", {62'd0, occupancy}, 64'd0);

        // ---------------- active gating ----------------
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'h5;
        cycle();
        bus.push_data  = 32'h6;
        cycle();
        active         = 1'b0;
        bus.pop_ready  = 1'b1;
        bus.push_data  = 32'h7;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("gate_push_ready", {63'd0, bus.push_ready}, 64'd0);
            check("gate_pop_valid", {63'd0, bus.pop_valid}, 64'd0);
            check("gate_pop_data", {32'd0, bus.pop_data}, 64'h5);
            cycle();
            check("gate_occupancy", {62'd0, occupancy}, 64'd2);
        end
        active         = 1'b1;
        bus.push_valid = 1'b0;
        cycle();
        check("gate_second", {32'd0, bus.pop_data}, 64'h6);
        cycle();
        check("gate_empty", {62'd0, occupancy}, 64'd0);

        // ---------------- mid-operation async reset ----------------
        bus.pop_ready  = 1'b0;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'h8;
        cycle();
        bus.push_data  = 32'h9;
        cycle();
        bus.push_valid = 1'b0;
        check("mr_full", {62'd0, occupancy}, 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("mr_occupancy", {62'd0, occupancy}, 64'd0);
        check("mr_pop_valid", {63'd0, bus.pop_valid}, 64'd0);
        check("mr_push_ready", {63'd0, bus.push_ready}, 64'd1);
        check("mr_pop_data", {32'd0, bus.pop_data}, {32'd0, RV});
        q.delete();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.pop_ready  = 1'b1;
        bus.push_valid = 1'b1;
        bus.push_data  = 32'h77;
        cycle();
        check("mr_first_word", {32'd0, bus.pop_data}, 64'h77);
        check("mr_alone", {62'd0, occupancy}, 64'd1);
        bus.push_valid = 1'b0;
        cycle();
        check("mr_after_pop", {63'd0, bus.pop_valid}, 64'd0);

        // ---------------- random ----------------
        for (int n = 0; n < 10000; n++) begin
            bus.push_valid = 1'($urandom_range(0, 1));
            bus.push_data  = $urandom;
            bus.pop_ready  = 1'($urandom_range(0, 1));
            cycle();
        end
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        for (int d = 0; d < 4; d++) cycle();
        check("final_queue_empty", 64'(q.size()), 64'd0);
        check("final_occupancy", {62'd0, occupancy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
